// File: rtl/metronome_pkg.sv
// metronome_pkg
// Shared types and constants for the metronome tempo path.
//   adj_state_t   : button-handling FSM states (IDLE, DELAY, REPEAT, BOTH)
//   BPM_W         : default tempo bus width
//   *_BPM / *_STEP: default tempo range, reset tempo and step sizes
package metronome_pkg;

    localparam int BPM_W           = 8;
    localparam int MIN_BPM         = 1;
    localparam int MAX_BPM         = 255;
    localparam int DEFAULT_BPM     = 120;
    localparam int FINE_STEP_DEF   = 1;
    localparam int COARSE_STEP_DEF = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2,
        BOTH   = 2'd3
    } adj_state_t;

endpackage

// File: rtl/hold_repeat_timer.sv
// hold_repeat_timer
// Button-handling FSM with the hold/auto-repeat counter. Decides *when* a
// step happens and in which direction; the arithmetic lives in the parent.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   restore         : level, forces IDLE and requests the default tempo
//   up, down        : debounced button levels
//   up_rise,down_rise: single-cycle rising-edge flags from the parent
//   step            : strobe, apply one step this cycle
//   step_up         : direction of the step (1 = up), valid with step
//   load_default    : strobe, load the default tempo this cycle
module hold_repeat_timer
    import metronome_pkg::*;
#(
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restore,
    input  logic up,
    input  logic down,
    input  logic up_rise,
    input  logic down_rise,
    output logic step,
    output logic step_up,
    output logic load_default
);

    localparam int MAX_CNT = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    adj_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             dir_up_reg, dir_up_next;
    logic             held;

    // Only reached when the buttons are not both high, so the held button
    // alone decides; a direction swap in one cycle reads as a release.
    assign held    = dir_up_reg ? up : down;
    assign step_up = dir_up_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            dir_up_reg <= 1'b1;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            dir_up_reg <= dir_up_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        dir_up_next  = dir_up_reg;
        step         = 1'b0;
        load_default = 1'b0;

        if (restore) begin
            load_default = 1'b1;
            state_next   = IDLE;
            cnt_next     = '0;
        end else if (up && down) begin
            // Default is loaded once on entry; staying in BOTH does nothing.
            load_default = (state_reg != BOTH);
            state_next   = BOTH;
            cnt_next     = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (up_rise || down_rise) begin
                        step        = 1'b1;
                        dir_up_next = up_rise;
                        cnt_next    = '0;
                        state_next  = DELAY;
                    end
                end
                DELAY: begin
                    if (!held) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (cnt_reg == HOLD_LAST) begin
                        step       = 1'b1;
                        cnt_next   = '0;
                        state_next = REPEAT;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!held) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (cnt_reg == REPEAT_LAST) begin
                        step     = 1'b1;
                        cnt_next = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                BOTH: begin
                    if (!up && !down) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/bpm_adjuster.sv
// bpm_adjuster
// Tempo register for the metronome: up/down buttons step the BPM with fine
// or coarse increments, wrapping or saturating at the range limits, with
// hold-to-auto-repeat and a both-buttons / restore return to default.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   up_btn, down_btn  : debounced button levels
//   restore           : level, load DEFAULT_VAL while high
//   coarse            : 1 selects COARSE_STEP, 0 selects FINE_STEP
//   wrap_en           : 1 wraps at the limits, 0 saturates
//   bpm               : current tempo (registered)
//   changed           : pulse in the cycle after bpm takes a new value
//   at_min, at_max    : registered limit flags
module bpm_adjuster
    import metronome_pkg::*;
#(
    parameter int WIDTH         = BPM_W,
    parameter int MIN_VAL       = MIN_BPM,
    parameter int MAX_VAL       = MAX_BPM,
    parameter int DEFAULT_VAL   = DEFAULT_BPM,
    parameter int FINE_STEP     = FINE_STEP_DEF,
    parameter int COARSE_STEP   = COARSE_STEP_DEF,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_btn,
    input  logic             down_btn,
    input  logic             restore,
    input  logic             coarse,
    input  logic             wrap_en,
    output logic [WIDTH-1:0] bpm,
    output logic             changed,
    output logic             at_min,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] DEF_W = WIDTH'(DEFAULT_VAL);
    localparam logic [WIDTH:0]   MIN_X = (WIDTH+1)'(MIN_VAL);
    localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   FINE_X   = (WIDTH+1)'(FINE_STEP);
    localparam logic [WIDTH:0]   COARSE_X = (WIDTH+1)'(COARSE_STEP);

    logic [WIDTH-1:0] bpm_reg, bpm_next;
    logic             upd_reg;       // bpm changed at the last edge
    logic             changed_reg;
    logic             at_min_reg, at_max_reg;
    logic             up_prev_reg, down_prev_reg;
    logic             up_rise, down_rise;
    logic             step, step_up, load_default;
    logic [WIDTH:0]   step_x, bpm_x, sum_x, diff_x;

    // Edge registers reset to 1 so a button held across reset must be
    // released and pressed again before it steps.
    assign up_rise   = up_btn && !up_prev_reg;
    assign down_rise = down_btn && !down_prev_reg;

    hold_repeat_timer #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .restore     (restore),
        .up          (up_btn),
        .down        (down_btn),
        .up_rise     (up_rise),
        .down_rise   (down_rise),
        .step        (step),
        .step_up     (step_up),
        .load_default(load_default)
    );

    // One guard bit so bpm+s cannot overflow before the limit compare.
    assign step_x = coarse ? COARSE_X : FINE_X;
    assign bpm_x  = {1'b0, bpm_reg};
    assign sum_x  = bpm_x + step_x;
    assign diff_x = bpm_x - step_x;

    always_comb begin
        bpm_next = bpm_reg;
        if (load_default) begin
            bpm_next = DEF_W;
        end else if (step) begin
            if (step_up) begin
                if (sum_x > MAX_X) bpm_next = wrap_en ? MIN_W : MAX_W;
                else               bpm_next = sum_x[WIDTH-1:0];
            end else begin
                if (bpm_x < MIN_X + step_x) bpm_next = wrap_en ? MAX_W : MIN_W;
                else                        bpm_next = diff_x[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bpm_reg       <= DEF_W;
            upd_reg       <= 1'b0;
            changed_reg   <= 1'b0;
            at_min_reg    <= (DEF_W == MIN_W);
            at_max_reg    <= (DEF_W == MAX_W);
            up_prev_reg   <= 1'b1;
            down_prev_reg <= 1'b1;
        end else begin
            bpm_reg       <= bpm_next;
            upd_reg       <= (bpm_next != bpm_reg);
            changed_reg   <= upd_reg;
            at_min_reg    <= (bpm_next == MIN_W);
            at_max_reg    <= (bpm_next == MAX_W);
            up_prev_reg   <= up_btn;
            down_prev_reg <= down_btn;
        end
    end

    assign bpm     = bpm_reg;
    assign changed = changed_reg;
    assign at_min  = at_min_reg;
    assign at_max  = at_max_reg;

endmodule

// File: tb/tb_bpm_adjuster.sv
// tb_bpm_adjuster
// Directed self-checking bench for bpm_adjuster with HOLD_CYCLES=4,
// REPEAT_CYCLES=2. Inputs change and outputs are sampled on the falling edge.
module tb_bpm_adjuster;

    logic       clk;
    logic       rst_n;
    logic       up_btn, down_btn, restore, coarse, wrap_en;
    logic [7:0] bpm;
    logic       changed, at_min, at_max;

    int n_checks;
    int n_fail;

    bpm_adjuster #(
        .HOLD_CYCLES  (4),
        .REPEAT_CYCLES(2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .up_btn  (up_btn),
        .down_btn(down_btn),
        .restore (restore),
        .coarse  (coarse),
        .wrap_en (wrap_en),
        .bpm     (bpm),
        .changed (changed),
        .at_min  (at_min),
        .at_max  (at_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle press, then two idle cycles so the changed pulse has passed.
    task automatic tap(input bit is_up, output bit saw);
        saw = 1'b0;
        if (is_up) up_btn = 1'b1; else down_btn = 1'b1;
        @(negedge clk); saw = saw | changed;
        up_btn = 1'b0; down_btn = 1'b0;
        @(negedge clk); saw = saw | changed;
        @(negedge clk); saw = saw | changed;
    endtask

    task automatic do_restore();
        restore = 1'b1;
        tick(1);
        restore = 1'b0;
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw;
        logic [7:0] hold_exp [10];
        hold_exp = '{8'd121, 8'd121, 8'd121, 8'd121, 8'd122,
                     8'd122, 8'd123, 8'd123, 8'd124, 8'd124};
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; up_btn = 0; down_btn = 0; restore = 0; coarse = 0; wrap_en = 0;

        // Reset state
        tick(2);
        check_val("rst_bpm", bpm, 120);
        check_val("rst_changed", changed, 0);
        check_val("rst_at_min", at_min, 0);
        check_val("rst_at_max", at_max, 0);
        rst_n = 1'b1;
        tick(2);

        // Single tap: step at the sampling edge, changed one cycle later
        up_btn = 1'b1;
        tick(1);
        check_val("tap_bpm", bpm, 121);
        check_val("tap_changed_t0", changed, 0);
        up_btn = 1'b0;
        tick(1);
        check_val("tap_changed_t1", changed, 1);
        tick(1);
        check_val("tap_changed_t2", changed, 0);
        tick(3);
        check_val("tap_one_step", bpm, 121);

        // Hold for 10 cycles: steps at +0, +4, +6, +8
        do_restore();
        check_val("restore_bpm", bpm, 120);
        up_btn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            check_val($sformatf("hold_k%0d", k), bpm, hold_exp[k]);
        end
        up_btn = 1'b0;
        tick(4);
        check_val("hold_release", bpm, 124);

        // Upper limit: saturate then wrap
        do_restore();
        coarse = 1'b1;
        for (int i = 0; i < 13; i++) tap(1'b1, saw);
        check_val("reach_250", bpm, 250);
        tap(1'b1, saw);
        check_val("sat_up_bpm", bpm, 255);
        check_val("sat_up_at_max", at_max, 1);
        tap(1'b1, saw);
        check_val("sat_up_again", bpm, 255);
        check_val("sat_up_nochange", saw, 0);
        wrap_en = 1'b1;
        tap(1'b1, saw);
        check_val("wrap_up_bpm", bpm, 1);
        check_val("wrap_up_at_min", at_min, 1);
        check_val("wrap_up_at_max", at_max, 0);

        // Lower limit: saturate, wrap, coarse saturate
        wrap_en = 1'b0; coarse = 1'b0;
        tap(1'b0, saw);
        check_val("sat_dn_bpm", bpm, 1);
        check_val("sat_dn_nochange", saw, 0);
        wrap_en = 1'b1;
        tap(1'b0, saw);
        check_val("wrap_dn_bpm", bpm, 255);
        check_val("wrap_dn_changed", saw, 1);
        tap(1'b1, saw);
        for (int i = 0; i < 4; i++) tap(1'b1, saw);
        check_val("reach_5", bpm, 5);
        wrap_en = 1'b0; coarse = 1'b1;
        tap(1'b0, saw);
        check_val("coarse_sat_dn", bpm, 1);
        check_val("coarse_sat_at_min", at_min, 1);

        // Both buttons -> default, no steps; lone held button needs re-press
        do_restore();
        tap(1'b1, saw);
        check_val("reach_130", bpm, 130);
        coarse = 1'b0;
        up_btn = 1'b1; down_btn = 1'b1;
        tick(1);
        check_val("both_default", bpm, 120);
        for (int k = 0; k < 7; k++) begin
            tick(1);
            check_val($sformatf("both_k%0d", k), bpm, 120);
        end
        down_btn = 1'b0;
        tick(5);
        check_val("both_up_left", bpm, 120);
        up_btn = 1'b0;
        tick(2);
        tap(1'b1, saw);
        check_val("both_repress", bpm, 121);

        // Asynchronous reset mid-repeat
        up_btn = 1'b1;
        tick(8);
        check_val("pre_reset_bpm", bpm, 124);
        #1 rst_n = 1'b0;
        #1;
        check_val("async_rst_bpm", bpm, 120);
        check_val("async_rst_changed", changed, 0);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        check_val("held_after_rst", bpm, 120);
        check_val("held_after_rst_chg", changed, 0);
        up_btn = 1'b0;
        tick(2);
        tap(1'b1, saw);
        check_val("press_after_rst", bpm, 121);
        check_val("press_after_rst_chg", saw, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
